// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (signed and unsigned), one bit per cycle.
// Operates on magnitudes, then applies signs in a final fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               neg_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    low_d   = low_q;
    mag_d   = mag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    abs_a   = (op[0] && opa[WIDTH-1]) ? -opa : opa;
    abs_b   = (op[0] && opb[WIDTH-1]) ? -opb : opb;
    msum    = acc_q + (low_q[0] ? {1'b0, mag_q} : '0);
    // Restoring divide: remainder gains the next dividend bit, keep the subtraction only if it did not borrow.
    shifted = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mag_q};
    prod    = {acc_q[WIDTH-1:0], low_q};
    neg_res = op_q[0] && (sa_q ^ sb_q);
    prod_s  = neg_res ? -prod : prod;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          op_d  = op;
          sa_d  = op[0] && opa[WIDTH-1];
          sb_d  = op[0] && opb[WIDTH-1];
          cnt_d = '0;
          if (op[1] && (opb == '0)) begin
            dz_d    = 1'b1;
            acc_d   = {1'b0, opa};
            low_d   = '1;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = '0;
            low_d   = op[1] ? abs_a : abs_b;
            mag_d   = op[1] ? abs_b : abs_a;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!op_q[1]) begin
            acc_d = {1'b0, msum[WIDTH:1]};
            low_d = {msum[0], low_q[WIDTH-1:1]};
          end else if (!diff[WIDTH+1]) begin
            acc_d = diff[WIDTH:0];
            low_d = {low_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted;
            low_d = {low_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CW'(WIDTH - 1))
            state_d = FIX;
        end
      end
      FIX: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          dbz_d   = dz_q;
          state_d = DONE;
          if (dz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = low_q;
          end else if (!op_q[1]) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end else begin
            // Remainder follows the dividend's sign; quotient is negated when signs differ.
            hi_d = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo_d = neg_res ? -low_q : low_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      low_q   <= '0;
      mag_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      mag_q   <= mag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign ready       = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected results,
// a negedge monitor pops and compares them whenever ready pulses.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, annul;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, ready, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fails  = 0;
  int           cyc      = 0;
  bit           mon_on   = 1'b0;
  logic [W-1:0] last_hi  = '0;
  logic [W-1:0] last_lo  = '0;
  logic         last_dbz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .annul(annul),
    .opa(opa), .opb(opb), .busy(busy), .ready(ready),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && ready !== 1'b0) begin
      if (sb.size() == 0) begin
        checkBit("unexpected_ready", ready, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("hi", hi, e.hi);
        checkOutput("lo", lo, e.lo);
        checkBit("div_by_zero", div_by_zero, e.dbz);
        checkOutput("ready_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit want, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                               input logic edbz);
    exp_t e;
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    if (want) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = cyc + ((o[1] && b == '0) ? 2 : W + 2);
      sb.push_back(e);
      last_hi  = ehi;
      last_lo  = elo;
      last_dbz = edbz;
    end
  endtask

  task automatic releaseStart();
    waitCycles(1);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() > 0 && n < W + 20) begin
      waitCycles(1);
      n++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL ready_timeout: got no ready, %0d results still expected", sb.size());
      sb.delete();
    end
  endtask

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    applyStimulus(o, a, b, 1'b1, ehi, elo, edbz);
    releaseStart();
    waitDrain();
  endtask

  task automatic checkIdleZero(input string tag);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_ready"}, ready, 1'b0);
    checkOutput({tag, "_hi"}, hi, '0);
    checkOutput({tag, "_lo"}, lo, '0);
    checkBit({tag, "_dbz"}, div_by_zero, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] prev_hi, prev_lo;
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; opa = '0; opb = '0;
    waitCycles(3);
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    checkIdleZero("reset");
    waitCycles(1);

    // Directed vectors, issued back-to-back in the cycle after each DONE.
    runOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    runOp(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    runOp(2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    runOp(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    runOp(2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
    runOp(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    runOp(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    runOp(2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    runOp(2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    runOp(2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0);

    // Annul in RUN ten cycles after the start, then a fresh start the cycle after.
    prev_hi = last_hi;
    prev_lo = last_lo;
    applyStimulus(2'b01, 32'd1234, 32'd5678, 1'b0, '0, '0, 1'b0);
    releaseStart();
    waitCycles(9);
    annul = 1'b1;
    waitCycles(1);
    annul = 1'b0;
    applyStimulus(2'b00, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0);
    @(negedge clk);
    checkBit("annul_busy", busy, 1'b0);
    checkOutput("annul_hi_kept", hi, prev_hi);
    checkOutput("annul_lo_kept", lo, prev_lo);
    waitCycles(1);
    start = 1'b0;
    waitDrain();

    // A start (which would be a quick divide-by-zero) issued while busy must be ignored.
    applyStimulus(2'b00, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0);
    releaseStart();
    waitCycles(3);
    applyStimulus(2'b10, 32'd9, 32'd0, 1'b0, '0, '0, 1'b0);
    releaseStart();
    waitDrain();

    // Annul asserted during DONE does not suppress the pulse.
    applyStimulus(2'b00, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
    releaseStart();
    waitCycles(W + 1);
    annul = 1'b1;
    waitCycles(1);
    annul = 1'b0;
    waitDrain();

    // Results hold steady while idle.
    waitCycles(4);
    @(negedge clk);
    checkOutput("hold_hi", hi, last_hi);
    checkOutput("hold_lo", lo, last_lo);
    checkBit("hold_dbz", div_by_zero, last_dbz);
    waitCycles(1);

    // Annul together with start in IDLE: start is refused.
    start = 1'b1; annul = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd2;
    waitCycles(1);
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    checkBit("annul_start_busy", busy, 1'b0);
    waitCycles(W + 4);

    // Reset five cycles into an operation clears everything, no ready follows.
    applyStimulus(2'b01, 32'd6, 32'd7, 1'b0, '0, '0, 1'b0);
    releaseStart();
    waitCycles(4);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    @(negedge clk);
    checkIdleZero("midop_reset");
    last_hi = '0;
    last_lo = '0;
    waitCycles(W + 5);

    runOp(2'b11, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

    waitCycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are even and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 multu, 01 mult, 10 divu, 11 div.
REQ-006 SHALL have port annul, input, 1 bit: cancel the operation in flight.
REQ-007 SHALL have port opa, input, WIDTH bits: multiplicand or dividend.
REQ-008 SHALL have port opb, input, WIDTH bits: multiplier or divisor.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and FIX states.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse marking hi/lo valid.
REQ-011 SHALL have port hi, output, WIDTH bits: product upper half or remainder.
REQ-012 SHALL have port lo, output, WIDTH bits: product lower half or quotient.
REQ-013 SHALL have port div_by_zero, output, 1 bit: qualified by ready; set for a div/divu with opb=0.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-015 SHALL, in IDLE with start=1 and annul=0, capture op and the operand magnitudes (two's-complement absolute value when signed), clear the iteration counter, and enter RUN.
REQ-016 SHALL perform one radix-2 step per cycle in RUN: shift-add for multiply, restoring subtract-shift for divide, on WIDTH+1-bit intermediates, plus a log2(WIDTH)+1-bit counter.
REQ-017 SHALL leave RUN for FIX after exactly WIDTH steps.
REQ-018 SHALL, in FIX, apply signs.
- mult: product negated iff opa and opb signs differ.
- div: quotient negated iff signs differ; remainder takes the dividend sign.
REQ-019 SHALL, in FIX, register hi/lo and enter DONE.
REQ-020 SHALL assert ready for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL have latency: start accepted at cycle t gives ready at cycle t+WIDTH+2.
REQ-022 SHALL hold hi, lo and div_by_zero stable after DONE until the next accepted start.
REQ-023 SHALL handle divide by zero as follows: when div/divu has opb=0, go IDLE->FIX directly (ready at t+2) with hi=opa, lo=all ones, div_by_zero=1.
REQ-024 SHALL return hi=0 and lo=most-negative value, with div_by_zero=0, for signed overflow (div of most-negative by -1).
REQ-025 SHALL ignore start while busy; the operands in flight are unaffected.
REQ-026 SHALL, on annul=1 in RUN or FIX, return to IDLE next cycle: no ready pulse, hi/lo unchanged.
REQ-027 SHALL, when annul=1 and start=1 in IDLE, not accept the start (annul wins).
REQ-028 SHALL, when annul=1 in DONE, still deliver the ready pulse (the result is already committed).
REQ-029 SHALL accept start in the cycle after DONE; back-to-back throughput is one operation per WIDTH+3 cycles.

Reset
REQ-030 SHALL, while rst=1 on a clock edge, enter IDLE, clear the counter and datapath, and drive busy=0, ready=0, hi=0, lo=0, div_by_zero=0.
REQ-031 SHALL let rst take priority over start and annul in every state.
REQ-032 SHALL, on rst mid-operation, abandon that operation without a ready pulse.

Verification (WIDTH=32, start at cycle t)
REQ-033 SHALL pass: multu 0xFFFFFFFF x 0xFFFFFFFF -> ready at t+34, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
REQ-034 SHALL pass: mult 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 SHALL pass: div 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL pass: divu 5 / 0 -> ready at t+2, div_by_zero=1, hi=0x00000005, lo=0xFFFFFFFF.
REQ-037 SHALL pass: annul at t+10 -> busy=0 at t+11 with no ready pulse, hi/lo retain the prior result, and a new start at t+11 completes normally.
REQ-038 SHALL pass: rst at t+5 -> all outputs 0 next cycle with no ready; start during busy has no effect on the result.
